mult_div_unit: RTL

- Sequential multiply/divide unit with HI/LO registers for the multicycle MIPS datapath. Executes MULT/MULTU/DIV/DIVU and supports MTHI/MTLO.
- Operands come from the A/B register outputs. The control unit drives start and waits on done.
- HI/LO feed extra inputs of the register-file write-data mux for MFHI/MFLO.
- div_zero feeds the exception cause logic (Cause/EPC path).

---
 rtl/mdu_pkg.sv | 19 +
 rtl/mdu_sign_fix.sv | 32 +++
 rtl/mult_div_unit.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit.
package mdu_pkg;

  localparam int unsigned MDU_ITER = 32;

  typedef enum logic [1:0] {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU} mdu_op_t;
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} mdu_state_t;

  // Multiply iterations needed for a multiplier magnitude: MSB index + 1, minimum 1.
  function automatic logic [7:0] mul_iters(input logic [63:0] mag);
    logic [7:0] n;
    n = 8'd1;
    for (int i = 0; i < 64; i++) begin
      if (mag[i]) n = 8'(i + 1);
    end
    return n;
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negation of a hi/lo pair, either per half or as one
// double-width value (wide_i, controlled by neg_lo_i).
module mdu_sign_fix #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  input  logic              neg_hi_i,
  input  logic              neg_lo_i,
  input  logic              wide_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [2*DATA_W-1:0] wide_in;
  logic [2*DATA_W-1:0] wide_neg;

  assign wide_in  = {hi_i, lo_i};
  assign wide_neg = '0 - wide_in;

  always_comb begin
    hi_o = hi_i;
    lo_o = lo_i;
    if (wide_i) begin
      if (neg_lo_i) {hi_o, lo_o} = wide_neg;
    end else begin
      if (neg_hi_i) hi_o = '0 - hi_i;
      if (neg_lo_i) lo_o = '0 - lo_i;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Sequential MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// Define MDU_EARLY_TERM_EN to stop multiplies after the highest set multiplier bit.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int unsigned W2 = 2 * DATA_W;

  mdu_state_t        state_q;
  logic [W2-1:0]     acc_q, acc_nx;
  logic [W2-1:0]     mcand_q, mcand_nx;
  logic [DATA_W-1:0] mplier_q, mplier_nx;
  logic [7:0]        cnt_q, mul_n;
  logic              neg_hi_q, neg_lo_q, dz_pend_q, done_q, dz_q;
  logic [DATA_W-1:0] hi_q, lo_q;

  logic              is_signed;
  logic [DATA_W-1:0] a_mag, b_mag, res_hi, res_lo;
  logic [DATA_W:0]   rem_sh, rem_new;
  logic              q_bit;

  assign is_signed = (op == OP_MULT) || (op == OP_DIV);

  mdu_sign_fix #(.DATA_W(DATA_W)) u_opnd_fix (
    .hi_i     (a),
    .lo_i     (b),
    .neg_hi_i (is_signed & a[DATA_W-1]),
    .neg_lo_i (is_signed & b[DATA_W-1]),
    .wide_i   (1'b0),
    .hi_o     (a_mag),
    .lo_o     (b_mag)
  );

`ifdef MDU_EARLY_TERM_EN
  assign mul_n = mul_iters(64'(b_mag));
`else
  assign mul_n = 8'(MDU_ITER);
`endif

  // Multiply: acc += mcand when the multiplier LSB is set. Divide: acc holds {rem, dividend/quotient}.
  always_comb begin
    acc_nx    = acc_q;
    mcand_nx  = mcand_q;
    mplier_nx = mplier_q;
    rem_sh    = '0;
    rem_new   = '0;
    q_bit     = 1'b0;
    if (state_q == DIV) begin
      rem_sh  = {acc_q[W2-1:DATA_W], acc_q[DATA_W-1]};
      q_bit   = rem_sh >= {1'b0, mcand_q[DATA_W-1:0]};
      rem_new = q_bit ? rem_sh - {1'b0, mcand_q[DATA_W-1:0]} : rem_sh;
      acc_nx  = {rem_new[DATA_W-1:0], acc_q[DATA_W-2:0], q_bit};
    end else begin
      if (mplier_q[0]) acc_nx = acc_q + mcand_q;
      mcand_nx  = mcand_q << 1;
      mplier_nx = mplier_q >> 1;
    end
  end

  mdu_sign_fix #(.DATA_W(DATA_W)) u_res_fix (
    .hi_i     (acc_nx[W2-1:DATA_W]),
    .lo_i     (acc_nx[DATA_W-1:0]),
    .neg_hi_i (neg_hi_q),
    .neg_lo_i (neg_lo_q),
    .wide_i   (state_q == MUL),
    .hi_o     (res_hi),
    .lo_o     (res_lo)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      neg_hi_q  <= 1'b0;
      neg_lo_q  <= 1'b0;
      dz_pend_q <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            // done_q high means this is the completion cycle; start is ignored there.
            if (!done_q) begin
              neg_hi_q  <= is_signed & a[DATA_W-1];
              neg_lo_q  <= is_signed & (a[DATA_W-1] ^ b[DATA_W-1]);
              dz_pend_q <= 1'b0;
              if (!op[1]) begin
                acc_q    <= '0;
                mcand_q  <= {{DATA_W{1'b0}}, a_mag};
                mplier_q <= b_mag;
                cnt_q    <= mul_n;
                state_q  <= MUL;
              end else if (b == '0) begin
                dz_pend_q <= 1'b1;
                state_q   <= FIN;
              end else begin
                acc_q   <= {{DATA_W{1'b0}}, a_mag};
                mcand_q <= {{DATA_W{1'b0}}, b_mag};
                cnt_q   <= 8'(MDU_ITER);
                state_q <= DIV;
              end
            end
          end else begin
            if (hi_we) hi_q <= wdata;
            if (lo_we) lo_q <= wdata;
          end
        end
        MUL, DIV: begin
          acc_q    <= acc_nx;
          mcand_q  <= mcand_nx;
          mplier_q <= mplier_nx;
          cnt_q    <= cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            hi_q    <= res_hi;
            lo_q    <= res_lo;
            state_q <= FIN;
          end
        end
        FIN: begin
          done_q    <= 1'b1;
          dz_q      <= dz_pend_q;
          dz_pend_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
